// File: rtl/rv_gpr_pkg.sv
// Shared types and constants for the RV32IM general-purpose register file.
// The optional same-cycle write bypass is selected with RV_GPR_BYPASS_EN.
package rv_gpr_pkg;

   localparam int GPR_ADDR_W = 5;
   localparam int GPR_NUM    = 2**GPR_ADDR_W;

   typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;

   localparam gpr_addr_t GPR_ZERO = '0;

   // x0 is hardwired to zero: it never stores data and never goes busy.
   function automatic logic gpr_is_real(gpr_addr_t addr);
      return addr != GPR_ZERO;
   endfunction

endpackage : rv_gpr_pkg

// File: rtl/rv_gpr_file_if.sv
// Bundle of read, issue, writeback and MDU signals around the register file.
// "master" is the pipeline side (decode, writeback, MDU).
// "slave" is the register file itself.
interface rv_gpr_file_if
   import rv_gpr_pkg::*;
#(
   parameter int XLEN = 32
) ();

   // Read ports
   gpr_addr_t        rs1_addr_i;
   logic [XLEN-1:0]  rs1_data_o;
   logic             rs1_busy_o;
   gpr_addr_t        rs2_addr_i;
   logic [XLEN-1:0]  rs2_data_o;
   logic             rs2_busy_o;

   // Long-latency issue
   logic             issue_valid_i;
   gpr_addr_t        issue_rd_i;
   logic             issue_ready_o;

   // In-order writeback
   logic             wb_valid_i;
   gpr_addr_t        wb_addr_i;
   logic [XLEN-1:0]  wb_data_i;

   // MDU result
   logic             mdu_valid_i;
   logic             mdu_ready_o;
   gpr_addr_t        mdu_addr_i;
   logic [XLEN-1:0]  mdu_data_i;

   // Scoreboard summary
   logic             pending_o;

   modport master (
      output rs1_addr_i, rs2_addr_i,
      input  rs1_data_o, rs1_busy_o, rs2_data_o, rs2_busy_o,
      output issue_valid_i, issue_rd_i,
      input  issue_ready_o,
      output wb_valid_i, wb_addr_i, wb_data_i,
      output mdu_valid_i, mdu_addr_i, mdu_data_i,
      input  mdu_ready_o,
      input  pending_o
   );

   modport slave (
      input  rs1_addr_i, rs2_addr_i,
      output rs1_data_o, rs1_busy_o, rs2_data_o, rs2_busy_o,
      input  issue_valid_i, issue_rd_i,
      output issue_ready_o,
      input  wb_valid_i, wb_addr_i, wb_data_i,
      input  mdu_valid_i, mdu_addr_i, mdu_data_i,
      output mdu_ready_o,
      output pending_o
   );

endinterface : rv_gpr_file_if

// File: rtl/rv_gpr_scoreboard.sv
// Pending-write scoreboard for the register file.
// It holds one busy bit per register. A bit is set by an accepted long-latency
// issue and cleared by an accepted MDU result.
// With RV_GPR_BYPASS_EN defined, a register being cleared this cycle already
// reads as not busy on the rs ports.
module rv_gpr_scoreboard
   import rv_gpr_pkg::*;
(
   input  logic      clk_i,
   input  logic      arstn_i,
   // Read-side lookups
   input  gpr_addr_t rs1_addr,
   input  gpr_addr_t rs2_addr,
   output logic      rs1_busy,
   output logic      rs2_busy,
   // Issue (set)
   input  logic      issue_valid,
   input  gpr_addr_t issue_rd,
   output logic      issue_ready,
   // MDU accept (clear)
   input  logic      clr_valid,
   input  gpr_addr_t clr_addr,
   // Writeback, observed only to flag writes to a pending register
   input  logic      wb_valid,
   input  gpr_addr_t wb_addr,
   // Summary
   output logic      pending
);

   logic [GPR_NUM-1:0] busy;
   logic [GPR_NUM-1:0] set_vec;
   logic [GPR_NUM-1:0] clr_vec;
   logic               issue_accept;

   // A pending register blocks a second issue to it (no WAW while in flight).
   assign issue_ready  = ~busy[issue_rd];
   assign issue_accept = issue_valid & issue_ready;
   assign pending      = |busy;

   // Decode the one-hot set and clear masks for this cycle.
   always_comb begin
      // NOTE: default every always_comb output first so no path infers a latch.
      set_vec = '0;
      clr_vec = '0;
      if (issue_accept && gpr_is_real(issue_rd)) begin
         set_vec[issue_rd] = 1'b1;
      end
      if (clr_valid && gpr_is_real(clr_addr)) begin
         clr_vec[clr_addr] = 1'b1;
      end
   end

   // Busy vector. A set and a clear on different registers both take effect.
   // A set and a clear on the same register cannot happen, because issue_ready
   // is low while that register is busy.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         busy <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop
         // samples pre-edge values regardless of statement order.
         busy <= (busy & ~clr_vec) | set_vec;
      end
   end

   // Per-port busy lookup. x0 is never busy because bit 0 is never set.
   always_comb begin
      rs1_busy = busy[rs1_addr];
      rs2_busy = busy[rs2_addr];
`ifdef RV_GPR_BYPASS_EN
      if (clr_valid && (clr_addr == rs1_addr)) begin
         rs1_busy = 1'b0;
      end
      if (clr_valid && (clr_addr == rs2_addr)) begin
         rs2_busy = 1'b0;
      end
`endif
   end

   // A writeback must not target a register that still waits for an MDU result.
   wb_to_busy_a : assert property (
      @(posedge clk_i) disable iff (!arstn_i)
      !(wb_valid && busy[wb_addr])
   ) else $error("writeback to pending register x%0d", wb_addr);

endmodule : rv_gpr_scoreboard

// File: rtl/rv_gpr_file.sv
// RV32IM general-purpose register file.
// It has two combinational read ports and two write sources: in-order
// writeback and the MDU result. A per-register scoreboard tracks pending
// MDU writes.
// Optional feature: RV_GPR_BYPASS_EN forwards same-cycle accepted writes to
// the read ports, checking writeback first and then the MDU.
module rv_gpr_file
   import rv_gpr_pkg::*;
#(
   parameter int              XLEN    = 32,
   parameter logic [XLEN-1:0] RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         arstn_i,
   rv_gpr_file_if.slave bus
);

   // x1..x31 only; x0 has no storage.
   logic [XLEN-1:0] regs [1:GPR_NUM-1];

   logic      wb_we;
   logic      mdu_accept;
   logic      mdu_we;
   gpr_addr_t rd_addr [2];
   logic [XLEN-1:0] rd_data [2];

   // Writeback always wins. The MDU is stalled in any cycle where wb is valid.
   assign bus.mdu_ready_o = ~bus.wb_valid_i;
   assign mdu_accept      = bus.mdu_valid_i & ~bus.wb_valid_i;
   assign wb_we           = bus.wb_valid_i & gpr_is_real(bus.wb_addr_i);
   assign mdu_we          = mdu_accept & gpr_is_real(bus.mdu_addr_i);

   // Register storage. At most one write source is active per cycle.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         // NOTE: this array is reset deliberately because software relies on a
         // defined value. That is why it maps to flops, not a RAM macro.
         for (int i = 1; i < GPR_NUM; i++) begin
            regs[i] <= RST_VAL;
         end
      end else if (wb_we) begin
         regs[bus.wb_addr_i] <= bus.wb_data_i;
      end else if (mdu_we) begin
         regs[bus.mdu_addr_i] <= bus.mdu_data_i;
      end
   end

   // Collect the read-port addresses so both ports share one lookup loop.
   always_comb begin
      rd_addr[0] = bus.rs1_addr_i;
      rd_addr[1] = bus.rs2_addr_i;
   end

   // Combinational read. x0 reads zero and is never forwarded.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = '0;
         if (gpr_is_real(rd_addr[p])) begin
            rd_data[p] = regs[rd_addr[p]];
`ifdef RV_GPR_BYPASS_EN
            if (wb_we && (bus.wb_addr_i == rd_addr[p])) begin
               rd_data[p] = bus.wb_data_i;
            end else if (mdu_we && (bus.mdu_addr_i == rd_addr[p])) begin
               rd_data[p] = bus.mdu_data_i;
            end
`endif
         end
      end
   end

   assign bus.rs1_data_o = rd_data[0];
   assign bus.rs2_data_o = rd_data[1];

   rv_gpr_scoreboard u_scoreboard (
      .clk_i       (clk_i),
      .arstn_i     (arstn_i),
      .rs1_addr    (bus.rs1_addr_i),
      .rs2_addr    (bus.rs2_addr_i),
      .rs1_busy    (bus.rs1_busy_o),
      .rs2_busy    (bus.rs2_busy_o),
      .issue_valid (bus.issue_valid_i),
      .issue_rd    (bus.issue_rd_i),
      .issue_ready (bus.issue_ready_o),
      .clr_valid   (mdu_accept),
      .clr_addr    (bus.mdu_addr_i),
      .wb_valid    (bus.wb_valid_i),
      .wb_addr     (bus.wb_addr_i),
      .pending     (bus.pending_o)
   );

endmodule : rv_gpr_file

// File: tb/tb_rv_gpr_file.sv
// Self-checking bench for rv_gpr_file: directed steps followed by a
// randomized phase, compared against a behavioural register/busy model.
// Expectations follow RV_GPR_BYPASS_EN when it is defined.
module tb_rv_gpr_file;
   import rv_gpr_pkg::*;

   localparam int XLEN = 32;

   logic clk   = 1'b0;
   logic arstn = 1'b0;
   always #5 clk = ~clk;

   rv_gpr_file_if #(.XLEN(XLEN)) bus ();

   rv_gpr_file #(.XLEN(XLEN), .RST_VAL(32'h0)) dut (
      .clk_i   (clk),
      .arstn_i (arstn),
      .bus     (bus.slave)
   );

   // Behavioural model: architectural registers, busy flags, in-flight MDU ops
   logic [31:0] m_regs [32];
   bit          m_busy [32];
   gpr_addr_t   m_q [$];

   int checks = 0;
   int errors = 0;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit mdu_acc();
      return bus.mdu_valid_i && !bus.wb_valid_i;
   endfunction

   function automatic logic [31:0] exp_read(gpr_addr_t a);
      if (a == 0) return 32'h0;
`ifdef RV_GPR_BYPASS_EN
      if (bus.wb_valid_i && bus.wb_addr_i == a) return bus.wb_data_i;
      if (mdu_acc() && bus.mdu_addr_i == a) return bus.mdu_data_i;
`endif
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(gpr_addr_t a);
      if (a == 0) return 1'b0;
`ifdef RV_GPR_BYPASS_EN
      if (mdu_acc() && bus.mdu_addr_i == a) return 1'b0;
`endif
      return m_busy[a];
   endfunction

   function automatic logic any_busy();
      for (int i = 0; i < 32; i++) if (m_busy[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 32'h0;
         m_busy[i] = 1'b0;
      end
      m_q.delete();
   endtask

   task automatic idle();
      bus.issue_valid_i = 1'b0;
      bus.issue_rd_i    = '0;
      bus.wb_valid_i    = 1'b0;
      bus.wb_addr_i     = '0;
      bus.wb_data_i     = '0;
      bus.mdu_valid_i   = 1'b0;
      bus.mdu_addr_i    = '0;
      bus.mdu_data_i    = '0;
   endtask

   // Compare every output against the model for the current inputs.
   task automatic check_all();
      check("rs1_data", bus.rs1_data_o, exp_read(bus.rs1_addr_i));
      check("rs2_data", bus.rs2_data_o, exp_read(bus.rs2_addr_i));
      check("rs1_busy", bus.rs1_busy_o, exp_busy(bus.rs1_addr_i));
      check("rs2_busy", bus.rs2_busy_o, exp_busy(bus.rs2_addr_i));
      check("issue_ready", bus.issue_ready_o, !m_busy[bus.issue_rd_i]);
      check("mdu_ready", bus.mdu_ready_o, !bus.wb_valid_i);
      check("pending", bus.pending_o, any_busy());
   endtask

   bit last_iss, last_macc;

   // Advance one clock and apply the spec's commit rules to the model.
   task automatic tick();
      bit iss, macc, wbv;
      gpr_addr_t rd, wa, ma;
      logic [31:0] wd, md;
      iss  = bus.issue_valid_i && !m_busy[bus.issue_rd_i];
      macc = mdu_acc();
      wbv  = bus.wb_valid_i;
      rd = bus.issue_rd_i; wa = bus.wb_addr_i; ma = bus.mdu_addr_i;
      wd = bus.wb_data_i;  md = bus.mdu_data_i;
      @(posedge clk);
      if (wbv && wa != 0) m_regs[wa] = wd;
      if (macc && ma != 0) m_regs[ma] = md;
      if (macc) m_busy[ma] = 1'b0;
      if (iss && rd != 0) m_busy[rd] = 1'b1;
      last_iss  = iss;
      last_macc = macc;
      #1;
   endtask

   initial begin
      // ---- Reset state ----
      model_reset();
      idle();
      bus.rs1_addr_i = 5'd1;
      bus.rs2_addr_i = 5'd31;
      #2;
      check("rst_pending", bus.pending_o, 1'b0);
      check("rst_issue_ready", bus.issue_ready_o, 1'b1);
      check("rst_mdu_ready", bus.mdu_ready_o, 1'b1);
      check("rst_rs1_data", bus.rs1_data_o, 32'h0);
      bus.wb_valid_i = 1'b1;
      #1;
      check("rst_mdu_ready_wb", bus.mdu_ready_o, 1'b0);
      bus.wb_valid_i = 1'b0;
      @(posedge clk); #1;
      arstn = 1'b1;
      @(posedge clk); #1;

      // ---- All 32 addresses read zero ----
      for (int i = 0; i < 32; i++) begin
         bus.rs1_addr_i = gpr_addr_t'(i);
         bus.rs2_addr_i = gpr_addr_t'(31 - i);
         #1;
         check("init_rs1", bus.rs1_data_o, 32'h0);
         check("init_rs2", bus.rs2_data_o, 32'h0);
      end
      check("init_pending", bus.pending_o, 1'b0);
      check("init_issue_ready", bus.issue_ready_o, 1'b1);
      @(posedge clk); #1;

      // ---- wb write x5, x0 write dropped ----
      bus.wb_valid_i = 1'b1; bus.wb_addr_i = 5'd5; bus.wb_data_i = 32'hDEADBEEF;
      #1; check_all(); tick();
      idle();
      bus.rs1_addr_i = 5'd5; bus.rs2_addr_i = 5'd0;
      #1;
      check("x5_after_wb", bus.rs1_data_o, 32'hDEADBEEF);
      check("x0_read", bus.rs2_data_o, 32'h0);
      bus.wb_valid_i = 1'b1; bus.wb_addr_i = 5'd0; bus.wb_data_i = 32'h1;
      #1; check_all(); tick();
      idle();
      #1;
      check("x0_after_wb", bus.rs2_data_o, 32'h0);

      // ---- Issue rd=7, WAW block, MDU completion ----
      bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd7;
      #1;
      check("issue7_ready", bus.issue_ready_o, 1'b1);
      check_all(); tick();
      bus.rs1_addr_i = 5'd7;
      #1;
      check("x7_busy", bus.rs1_busy_o, 1'b1);
      check("x7_pending", bus.pending_o, 1'b1);
      check("x7_reissue_ready", bus.issue_ready_o, 1'b0);
      check_all(); tick();
      idle();
      bus.mdu_valid_i = 1'b1; bus.mdu_addr_i = 5'd7; bus.mdu_data_i = 32'h12345678;
      #1; check_all(); tick();
      idle();
      #1;
      check("x7_busy_clear", bus.rs1_busy_o, 1'b0);
      check("x7_data", bus.rs1_data_o, 32'h12345678);
      check("x7_pending_clear", bus.pending_o, 1'b0);

      // ---- wb and MDU collide ----
      bus.wb_valid_i  = 1'b1; bus.wb_addr_i  = 5'd3; bus.wb_data_i  = 32'h1;
      bus.mdu_valid_i = 1'b1; bus.mdu_addr_i = 5'd9; bus.mdu_data_i = 32'h2;
      #1;
      check("collide_mdu_ready", bus.mdu_ready_o, 1'b0);
      check_all(); tick();
      bus.wb_valid_i = 1'b0;
      bus.rs1_addr_i = 5'd3; bus.rs2_addr_i = 5'd9;
      #1;
      check("collide_x3", bus.rs1_data_o, 32'h1);
      check("collide_mdu_ready_idle", bus.mdu_ready_o, 1'b1);
      check_all(); tick();
      idle();
      #1;
      check("collide_x9", bus.rs2_data_o, 32'h2);

      // ---- Same-cycle set and clear on different registers ----
      bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd6;
      #1; check_all(); tick();
      bus.issue_rd_i = 5'd4;
      bus.mdu_valid_i = 1'b1; bus.mdu_addr_i = 5'd6; bus.mdu_data_i = 32'h66;
      #1; check_all(); tick();
      idle();
      bus.rs1_addr_i = 5'd4; bus.rs2_addr_i = 5'd6;
      #1;
      check("setclr_busy4", bus.rs1_busy_o, 1'b1);
      check("setclr_busy6", bus.rs2_busy_o, 1'b0);
      check("setclr_x6", bus.rs2_data_o, 32'h66);
      bus.mdu_valid_i = 1'b1; bus.mdu_addr_i = 5'd4; bus.mdu_data_i = 32'h44;
      #1; check_all(); tick();
      idle();
      #1; check_all();

      // ---- Reset mid-operation ----
      bus.wb_valid_i = 1'b1; bus.wb_addr_i = 5'd2; bus.wb_data_i = 32'hA5;
      #1; check_all(); tick();
      idle();
      bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd2;
      #1; check_all(); tick();
      idle();
      bus.rs1_addr_i = 5'd2;
      #1;
      check("pre_rst_x2", bus.rs1_data_o, 32'hA5);
      check("pre_rst_pending", bus.pending_o, 1'b1);
      arstn = 1'b0;
      #1;
      model_reset();
      check("mid_rst_pending", bus.pending_o, 1'b0);
      check("mid_rst_x2", bus.rs1_data_o, 32'h0);
      check("mid_rst_busy", bus.rs1_busy_o, 1'b0);
      @(posedge clk); #2;
      arstn = 1'b1;
      @(posedge clk); #1;

      // ---- Same-cycle read of a write (bypass or old value) ----
      bus.wb_valid_i = 1'b1; bus.wb_addr_i = 5'd8; bus.wb_data_i = 32'h33;
      #1; check_all(); tick();
      bus.wb_data_i = 32'h55; bus.rs1_addr_i = 5'd8;
      #1;
`ifdef RV_GPR_BYPASS_EN
      check("bypass_x8", bus.rs1_data_o, 32'h55);
`else
      check("nobypass_x8", bus.rs1_data_o, 32'h33);
`endif
      check_all(); tick();
      idle();
      #1;
      check("x8_committed", bus.rs1_data_o, 32'h55);

      // ---- Randomized traffic against the model ----
      for (int n = 0; n < 1500; n++) begin
         gpr_addr_t wa;
         bus.rs1_addr_i = gpr_addr_t'($urandom_range(0, 31));
         bus.rs2_addr_i = gpr_addr_t'($urandom_range(0, 31));
         bus.issue_valid_i = ($urandom_range(0, 9) < 4);
         bus.issue_rd_i    = gpr_addr_t'($urandom_range(0, 31));
         wa = gpr_addr_t'($urandom_range(0, 31));
         bus.wb_valid_i = ($urandom_range(0, 1) == 1) && !m_busy[wa];
         bus.wb_addr_i  = wa;
         bus.wb_data_i  = $urandom;
         // The MDU holds valid/addr/data until the result is accepted.
         if (!bus.mdu_valid_i && m_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            bus.mdu_valid_i = 1'b1;
            bus.mdu_addr_i  = m_q[0];
            bus.mdu_data_i  = $urandom;
         end
         #1; check_all();
         tick();
         if (last_macc) begin
            void'(m_q.pop_front());
            bus.mdu_valid_i = 1'b0;
         end
         if (last_iss && bus.issue_rd_i != 0) m_q.push_back(bus.issue_rd_i);
      end
      idle();
      #1; check_all();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rv_gpr_file

// File: doc/rv_gpr_file.md
Name: rv_gpr_file

Overview:
- RV32IM general-purpose register file: 2 combinational read ports, 2 write sources, and a per-register pending-write scoreboard.
- Write sources are the in-order writeback port and the long-latency MUL/DIV unit (MDU) result port.
- Sits between decode (reads, issue) and writeback/MDU (writes).
- Register address width comes from rv_gpr_pkg::GPR_ADDR_W (5).

Parameters:
- XLEN, 32, data width of each register.
- RST_VAL, 32'h0, value loaded into x1..x31 on reset.

Ports:
- clk_i  in  1  core clock, rising edge.
- arstn_i  in  1  asynchronous active-low reset.
- rs1_addr_i  in  GPR_ADDR_W  read port 1 address.
- rs1_data_o  out  XLEN  read port 1 data.
- rs1_busy_o  out  1  rs1 has a pending MDU write.
- rs2_addr_i  in  GPR_ADDR_W  read port 2 address.
- rs2_data_o  out  XLEN  read port 2 data.
- rs2_busy_o  out  1  rs2 has a pending MDU write.
- issue_valid_i  in  1  decode issues a long-latency op.
- issue_rd_i  in  GPR_ADDR_W  destination of the issued op.
- issue_ready_o  out  1  issue accepted this cycle.
- wb_valid_i  in  1  pipeline writeback strobe.
- wb_addr_i  in  GPR_ADDR_W  writeback destination.
- wb_data_i  in  XLEN  writeback data.
- mdu_valid_i  in  1  MDU result valid.
- mdu_ready_o  out  1  MDU result accepted.
- mdu_addr_i  in  GPR_ADDR_W  MDU destination.
- mdu_data_i  in  XLEN  MDU result.
- pending_o  out  1  any busy bit set.

Behaviour:
- Reset is asynchronous on arstn_i low: x1..x31 <= RST_VAL, all busy bits <= 0.
- Outputs during reset: pending_o=0, issue_ready_o=1, mdu_ready_o=!wb_valid_i. Read data reflects RST_VAL (0 for x0).
- x0: reads always 0 and busy=0. Writes to x0 from either port are dropped. Issue with rd=0 is accepted and sets no busy bit.
- Reads are combinational, latency 0. Writes commit at the rising edge and are visible on reads from the next cycle, unless the bypass feature is enabled.
- Write arbitration:
  - The wb port always wins and is never stalled.
  - mdu_ready_o = !wb_valid_i.
  - MDU accept = mdu_valid_i & mdu_ready_o.
  - MDU must hold addr/data stable until accepted.
- Scoreboard:
  - issue_ready_o = !busy[issue_rd_i] (always 1 for rd=0). Blocks WAW on a pending register.
  - Issue accept = issue_valid_i & issue_ready_o; sets busy[issue_rd_i] at the edge.
  - MDU accept clears busy[mdu_addr_i] at the edge.
  - Same-cycle set and clear on different addresses: both apply.
  - Same-cycle set and clear on the same address cannot occur, because issue_ready_o is low while busy.
  - MDU accept to a non-busy register: data is written, busy is unchanged.
- wb_valid_i to a busy register is a protocol violation. RTL writes the data and leaves busy unchanged; a simulation-only assertion fires.
- pending_o = OR of all busy bits, combinational from state.
- rs1_busy_o / rs2_busy_o are combinational from busy bits. A clear in the current cycle is not reflected until the next cycle.
- Reset mid-operation: all busy bits clear immediately. Any MDU result arriving after reset is written as a normal write; the MDU is reset by the same arstn_i.

Optional Feature:
- Macro: RV_GPR_BYPASS_EN.
- Defined: a read whose address matches an accepted write in the same cycle returns the write data combinationally, wb port first, then MDU accept. The busy bit for an address being cleared by a same-cycle MDU accept reads as 0. x0 is never bypassed.
- Undefined: reads return the pre-edge register contents and the busy flag reflects stored state only.

Decomposition:
- rv_gpr_pkg gains:
  - typedef gpr_addr_t = logic [GPR_ADDR_W-1:0];
  - constant GPR_NUM = 2**GPR_ADDR_W;
  - constant GPR_ZERO = '0.
- One sub-module, rv_gpr_scoreboard: the busy-bit vector, issue_ready_o, rs*_busy_o and pending_o.
- The storage array and arbitration stay in rv_gpr_file.

Test Plan:
- Reset then read all 32 addresses -> every rs*_data_o = 0, pending_o=0, issue_ready_o=1.
- wb write x5=32'hDEADBEEF; next cycle rs1=5, rs2=0 -> rs1_data_o=DEADBEEF, rs2_data_o=0. A wb write to x0=32'h1 -> x0 still reads 0.
- Issue rd=7 -> rs1_busy_o=1 for rs1=7, pending_o=1, and a second issue rd=7 gives issue_ready_o=0. MDU accept x7=32'h12345678 -> busy cleared next cycle, x7 reads 12345678.
- wb_valid_i and mdu_valid_i together (wb x3=1, mdu x9=2) -> mdu_ready_o=0, x3=1. The next cycle with wb idle -> mdu accepted, x9=2.
- Same cycle: issue rd=4 while MDU accepts x6 (x6 busy) -> busy[4]=1, busy[6]=0 afterwards.
- arstn_i low mid-operation with x2 busy and x2=32'hA5 -> immediately pending_o=0 and x2 reads 0. With RV_GPR_BYPASS_EN: a same-cycle wb x8=32'h55 with rs1=8 -> rs1_data_o=55 that cycle; without the macro -> the old value.
